// File: rtl/poly_mult_pkg.sv
// Shared definitions for the ternary polynomial multiplier: default sizes,
// ternary coefficient encodings and the FSM state type.
package poly_mult_pkg;

    localparam int unsigned DEF_N = 512;
    localparam int unsigned DEF_W = 8;
    localparam int unsigned DEF_L = 1;

    localparam logic [1:0] TRN_ZERO = 2'b00;
    localparam logic [1:0] TRN_POS  = 2'b01;
    localparam logic [1:0] TRN_NEG  = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

endpackage

// File: rtl/poly_rotate_neg.sv
// Multiplies a polynomial by x^SHIFT: rotates coefficients up by SHIFT places,
// negating the wrapped ones in the negacyclic ring (mode=0).
module poly_rotate_neg
    import poly_mult_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned W     = DEF_W,
    parameter int unsigned SHIFT = 1
) (
    input  logic           mode,
    input  logic [W*N-1:0] a,
    output logic [W*N-1:0] y
);

    always_comb begin
        y = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // Source index computed modulo N so no branch ever forms a negative index.
            if ((k < SHIFT) && !mode)
                y[W*k +: W] = '0 - a[W*((k + N - SHIFT) % N) +: W];
            else
                y[W*k +: W] = a[W*((k + N - SHIFT) % N) +: W];
        end
    end

endmodule

// File: rtl/poly_mult_ternary.sv
// Ternary-by-integer polynomial multiplier in Z_{2^W}[x]/(x^N +- 1),
// consuming L ternary coefficients per cycle over N/L cycles.
module poly_mult_ternary
    import poly_mult_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned W = DEF_W,
    parameter int unsigned L = DEF_L
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_start,
    input  logic           i_mode,
    input  logic [W*N-1:0] i_poly_a,
    input  logic [2*N-1:0] i_poly_r,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_valid,
    output logic [W*N-1:0] o_result
);

    localparam int unsigned STEPS = N / L;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    state_t         state, state_next;
    logic [CW-1:0]  cnt;
    logic           mode_q;
    logic [2*N-1:0] r_q;
    logic [W*N-1:0] rot_q;
    logic [W*N-1:0] acc, acc_next;
    logic [W*N-1:0] rot [0:L];
    logic           accept;

    assign accept   = (state == ST_IDLE) && i_start;
    assign o_busy   = (state == ST_RUN);
    assign o_result = acc;
    assign rot[0]   = rot_q;

    // rot[s] = (a * x^(j+s)); rot[L] is the next shift-register value.
    for (genvar s = 1; s <= int'(L); s++) begin : g_rot
        poly_rotate_neg #(.N(N), .W(W), .SHIFT(s)) u_rot (
            .mode (mode_q),
            .a    (rot_q),
            .y    (rot[s])
        );
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (i_start)      state_next = ST_RUN;
            ST_RUN:  if (cnt == LAST)  state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_next = acc;
        for (int unsigned l = 0; l < L; l++) begin
            for (int unsigned k = 0; k < N; k++) begin
                case (r_q[2*l +: 2])
                    TRN_POS: acc_next[W*k +: W] = acc_next[W*k +: W] + rot[l][W*k +: W];
                    TRN_NEG: acc_next[W*k +: W] = acc_next[W*k +: W] - rot[l][W*k +: W];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt     <= '0;
            mode_q  <= 1'b0;
            r_q     <= '0;
            rot_q   <= '0;
            acc     <= '0;
            o_done  <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (accept) begin
                rot_q   <= i_poly_a;
                r_q     <= i_poly_r;
                mode_q  <= i_mode;
                acc     <= '0;
                cnt     <= '0;
                o_valid <= 1'b0;
            end else if (state == ST_RUN) begin
                acc   <= acc_next;
                rot_q <= rot[L];
                r_q   <= r_q >> (2 * L);
                cnt   <= cnt + 1'b1;
                if (cnt == LAST) begin
                    o_done  <= 1'b1;
                    o_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_poly_mult_ternary.sv
// Directed and randomised checks of poly_mult_ternary at N=4 (L=1, L=2)
// and N=512 (L=4) against hand-computed values and a convolution model.
module tb_poly_mult_ternary;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        sa, ma, busy_a, done_a, valid_a;
    logic [31:0] aa, res_a;
    logic [7:0]  ra;
    logic        sb, mb, busy_b, done_b, valid_b;
    logic [31:0] ab, res_b;
    logic [7:0]  rb;
    logic          sc, mc, busy_c, done_c, valid_c;
    logic [4095:0] ac, res_c;
    logic [1023:0] rc;

    poly_mult_ternary #(.N(4), .W(8), .L(1)) u_a (
        .i_clock(clk), .i_reset(rst_n), .i_start(sa), .i_mode(ma),
        .i_poly_a(aa), .i_poly_r(ra), .o_busy(busy_a), .o_done(done_a),
        .o_valid(valid_a), .o_result(res_a));

    poly_mult_ternary #(.N(4), .W(8), .L(2)) u_b (
        .i_clock(clk), .i_reset(rst_n), .i_start(sb), .i_mode(mb),
        .i_poly_a(ab), .i_poly_r(rb), .o_busy(busy_b), .o_done(done_b),
        .o_valid(valid_b), .o_result(res_b));

    poly_mult_ternary #(.N(512), .W(8), .L(4)) u_c (
        .i_clock(clk), .i_reset(rst_n), .i_start(sc), .i_mode(mc),
        .i_poly_a(ac), .i_poly_r(rc), .o_busy(busy_c), .o_done(done_c),
        .o_valid(valid_c), .o_result(res_c));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          sel;
        logic        mode;
        logic [31:0] a;
        logic [7:0]  r;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    function automatic logic get_done(bit sel);   return sel ? done_b  : done_a;  endfunction
    function automatic logic get_busy(bit sel);   return sel ? busy_b  : busy_a;  endfunction
    function automatic logic get_valid(bit sel);  return sel ? valid_b : valid_a; endfunction
    function automatic logic [31:0] get_res(bit sel); return sel ? res_b : res_a; endfunction

    task automatic drive(input bit sel, input logic s, input logic m,
                         input logic [31:0] a, input logic [7:0] r);
        if (sel) begin sb = s; mb = m; ab = a; rb = r; end
        else     begin sa = s; ma = m; aa = a; ra = r; end
    endtask

    task automatic wait_done(input bit sel, input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            if (get_done(sel)) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   lat;
        logic [31:0] held;
        v = vecs[i];
        @(negedge clk);
        drive(v.sel, 1'b1, v.mode, v.a, v.r);
        @(posedge clk); #1;
        drive(v.sel, 1'b0, v.mode, v.a, v.r);
        check($sformatf("v%0d_busy_after_start", i), get_busy(v.sel), 1);
        check($sformatf("v%0d_valid_cleared", i), get_valid(v.sel), 0);
        wait_done(v.sel, 10, lat);
        check($sformatf("v%0d_latency", i), lat, v.sel ? 2 : 4);
        check($sformatf("v%0d_result", i), get_res(v.sel), v.exp);
        check($sformatf("v%0d_valid", i), get_valid(v.sel), 1);
        check($sformatf("v%0d_idle", i), get_busy(v.sel), 0);
        held = get_res(v.sel);
        @(posedge clk); #1;
        check($sformatf("v%0d_done_pulse", i), get_done(v.sel), 0);
        check($sformatf("v%0d_result_hold", i), get_res(v.sel), held);
        check($sformatf("v%0d_valid_hold", i), get_valid(v.sel), 1);
    endtask

    task automatic run_c(input logic mode);
        logic [7:0] exp_c [512];
        logic [7:0] t, s;
        logic [1:0] code;
        int lat, nbad;
        for (int k = 0; k < 512; k++) ac[8*k +: 8] = 8'($urandom);
        for (int k = 0; k < 512; k++) rc[2*k +: 2] = 2'($urandom_range(0, 3));
        for (int k = 0; k < 512; k++) begin
            s = '0;
            for (int j = 0; j < 512; j++) begin
                code = rc[2*j +: 2];
                if (code == 2'b01 || code == 2'b11) begin
                    if (k >= j) t = ac[8*(k-j) +: 8];
                    else begin
                        t = ac[8*(k+512-j) +: 8];
                        if (!mode) t = 8'd0 - t;
                    end
                    s = (code == 2'b01) ? s + t : s - t;
                end
            end
            exp_c[k] = s;
        end
        @(negedge clk);
        sc = 1'b1; mc = mode;
        @(posedge clk); #1;
        sc = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (done_c) begin lat = c; break; end
        end
        check($sformatf("c_mode%0d_latency", mode), lat, 128);
        nbad = 0;
        for (int k = 0; k < 512; k++) if (res_c[8*k +: 8] !== exp_c[k]) nbad++;
        check($sformatf("c_mode%0d_coef_mismatches", mode), nbad, 0);
        check($sformatf("c_mode%0d_valid", mode), valid_c, 1);
    endtask

    initial begin
        int lat, seen;

        vecs[0] = '{1'b0, 1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, 8'b00_00_01_00, {8'd3, 8'd2, 8'd1, 8'd252}};
        vecs[1] = '{1'b0, 1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, 8'b00_00_01_00, {8'd3, 8'd2, 8'd1, 8'd4}};
        vecs[2] = '{1'b0, 1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, 8'b00_00_00_11, {8'd252, 8'd253, 8'd254, 8'd255}};
        vecs[3] = '{1'b0, 1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, 8'b01_00_11_01, {8'd2, 8'd5, 8'd4, 8'd255}};
        vecs[4] = '{1'b0, 1'b0, {8'd1, 8'd1, 8'd1, 8'd1}, 8'b01_01_01_01, {8'd4, 8'd2, 8'd0, 8'd254}};
        vecs[5] = '{1'b0, 1'b0, {8'd25, 8'd50, 8'd100, 8'd200}, 8'b00_00_01_01, {8'd75, 8'd150, 8'd44, 8'd175}};
        vecs[6] = '{1'b1, 1'b0, {8'd1, 8'd1, 8'd1, 8'd1}, 8'b01_01_01_01, {8'd4, 8'd2, 8'd0, 8'd254}};
        vecs[7] = '{1'b1, 1'b0, {8'd1, 8'd1, 8'd1, 8'd1}, 8'b01_01_10_01, {8'd3, 8'd1, 8'd255, 8'd255}};
        vecs[8] = '{1'b1, 1'b0, {8'd1, 8'd1, 8'd1, 8'd1}, 8'b01_01_00_01, {8'd3, 8'd1, 8'd255, 8'd255}};
        vecs[9] = '{1'b1, 1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, 8'b00_00_01_00, {8'd3, 8'd2, 8'd1, 8'd4}};

        rst_n = 1'b0;
        sa = 0; ma = 0; aa = '0; ra = '0;
        sb = 0; mb = 0; ab = '0; rb = '0;
        sc = 0; mc = 0; ac = '0; rc = '0;
        #12;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_result", res_a, 0);
        check("rst_result_b", res_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(i);

        // Reset two cycles into a run: outputs clear at once, no done follows.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, vecs[0].a, vecs[0].r);
        @(posedge clk); #1;
        sa = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", busy_a, 0);
        check("midrun_rst_done", done_a, 0);
        check("midrun_rst_valid", valid_a, 0);
        check("midrun_rst_result", res_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done_a) seen++;
        end
        check("midrun_no_done", seen, 0);
        check("midrun_still_idle", busy_a, 0);

        // Start presented on the first edge after reset release.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, vecs[2].mode, vecs[2].a, vecs[2].r);
        @(posedge clk); #1;
        sa = 1'b0;
        check("rel_start_busy", busy_a, 1);
        wait_done(0, 10, lat);
        check("rel_start_latency", lat, 4);
        check("rel_start_result", res_a, vecs[2].exp);

        // Start held and inputs scrambled while busy must not disturb the run.
        @(negedge clk);
        drive(0, 1'b1, vecs[0].mode, vecs[0].a, vecs[0].r);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'hDEADBEEF, 8'hFF);
        wait_done(0, 10, lat);
        check("busy_ignore_latency", lat, 4);
        check("busy_ignore_result", res_a, vecs[0].exp);

        // Back-to-back: start in the done cycle is taken on the next edge.
        drive(0, 1'b1, vecs[1].mode, vecs[1].a, vecs[1].r);
        @(posedge clk); #1;
        sa = 1'b0;
        check("b2b_busy", busy_a, 1);
        check("b2b_valid_cleared", valid_a, 0);
        wait_done(0, 10, lat);
        check("b2b_latency", lat, 4);
        check("b2b_result", res_a, vecs[1].exp);

        run_c(1'b0);
        run_c(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
